// File: rtl/pattern_sequencer_if.sv
// Command and channel-output bundle between the UART decoder, pattern_sequencer and the pins.
// master drives commands and observes the outputs; slave is the sequencer side.
interface pattern_sequencer_if #(
  parameter int DATA_BIT    = 32,
  parameter int CHANNEL_NUM = 16
);
  logic                   cmd_valid_i;
  logic [DATA_BIT-1:0]    output_pattern_i;
  logic [DATA_BIT-1:0]    freq_pattern_i;
  logic [3:0]             sel_out_i;
  logic                   mode_i;
  logic                   start_i;
  logic                   stop_i;
  logic [CHANNEL_NUM-1:0] serial_o;
  logic                   busy_o;
  logic                   bit_tick_o;
  logic                   done_tick_o;
  logic                   err_tick_o;

  modport master (
    output cmd_valid_i, output_pattern_i, freq_pattern_i, sel_out_i, mode_i, start_i, stop_i,
    input  serial_o, busy_o, bit_tick_o, done_tick_o, err_tick_o
  );

  modport slave (
    input  cmd_valid_i, output_pattern_i, freq_pattern_i, sel_out_i, mode_i, start_i, stop_i,
    output serial_o, busy_o, bit_tick_o, done_tick_o, err_tick_o
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Emits one latched pattern bit-serially onto a selected channel; first bit appears the cycle after acceptance.
// Bit order is LSB first unless SEQ_MSB_FIRST_EN is defined (then MSB first).
module pattern_sequencer #(
  parameter int DATA_BIT    = 32,
  parameter int CHANNEL_NUM = 16,
  parameter int DIV_BIT     = 8,
  parameter int HIGH_DIV    = 10,
  parameter int LOW_DIV     = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pattern_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                 IDX_W     = $clog2(DATA_BIT);
  localparam logic [DIV_BIT-1:0] HIGH_LOAD = DIV_BIT'(HIGH_DIV - 1);
  localparam logic [DIV_BIT-1:0] LOW_LOAD  = DIV_BIT'(LOW_DIV - 1);

  // The shift/freq registers rotate so the bit being emitted always sits at HEAD;
  // after DATA_BIT rotations they hold the original pattern again, which makes repeat free.
`ifdef SEQ_MSB_FIRST_EN
  localparam int               HEAD      = DATA_BIT - 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DATA_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = '0;
`else
  localparam int               HEAD      = 0;
  localparam logic [IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BIT - 1);
`endif

  state_t                 r_state;
  logic [DATA_BIT-1:0]    r_shift;
  logic [DATA_BIT-1:0]    r_freq;
  logic [3:0]             r_ch;
  logic                   r_mode;
  logic [IDX_W-1:0]       r_idx;
  logic [DIV_BIT-1:0]     r_cnt;
  logic [CHANNEL_NUM-1:0] r_serial;
  logic                   r_busy;
  logic                   r_bit_tick;
  logic                   r_done_tick;
  logic                   r_err_tick;

  state_t                 w_state;
  logic [DATA_BIT-1:0]    w_shift;
  logic [DATA_BIT-1:0]    w_freq;
  logic [3:0]             w_ch;
  logic                   w_mode;
  logic [IDX_W-1:0]       w_idx;
  logic [DIV_BIT-1:0]     w_cnt;
  logic [CHANNEL_NUM-1:0] w_serial;
  logic                   w_bit_tick;
  logic                   w_err_tick;

  logic [DATA_BIT-1:0]    w_shift_rot;
  logic [DATA_BIT-1:0]    w_freq_rot;
  logic [IDX_W-1:0]       w_idx_adv;
  logic                   w_cmd_stop;
  logic                   w_cmd_start;
  logic                   w_sel_bad;

`ifdef SEQ_MSB_FIRST_EN
  assign w_shift_rot = {r_shift[DATA_BIT-2:0], r_shift[DATA_BIT-1]};
  assign w_freq_rot  = {r_freq[DATA_BIT-2:0], r_freq[DATA_BIT-1]};
  assign w_idx_adv   = r_idx - 1'b1;
`else
  assign w_shift_rot = {r_shift[0], r_shift[DATA_BIT-1:1]};
  assign w_freq_rot  = {r_freq[0], r_freq[DATA_BIT-1:1]};
  assign w_idx_adv   = r_idx + 1'b1;
`endif

  assign w_cmd_stop  = bus.cmd_valid_i & bus.stop_i;
  assign w_cmd_start = bus.cmd_valid_i & bus.start_i & ~bus.stop_i;
  assign w_sel_bad   = (int'(bus.sel_out_i) >= CHANNEL_NUM);

  function automatic logic [CHANNEL_NUM-1:0] chan_vec(input logic [3:0] ch, input logic b);
    logic [CHANNEL_NUM-1:0] v;
    v = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      v[c] = b && (int'(ch) == c);
    end
    return v;
  endfunction

  function automatic logic [DIV_BIT-1:0] load_of(input logic f);
    return f ? HIGH_LOAD : LOW_LOAD;
  endfunction

  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_freq     = r_freq;
    w_ch       = r_ch;
    w_mode     = r_mode;
    w_idx      = r_idx;
    w_cnt      = r_cnt;
    w_serial   = r_serial;
    w_bit_tick = 1'b0;
    w_err_tick = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state  = S_IDLE;
        w_serial = '0;
        if (w_cmd_start) begin
          if (w_sel_bad) begin
            w_err_tick = 1'b1;
          end else begin
            w_state    = S_RUN;
            w_shift    = bus.output_pattern_i;
            w_freq     = bus.freq_pattern_i;
            w_ch       = bus.sel_out_i;
            w_mode     = bus.mode_i;
            w_idx      = IDX_FIRST;
            w_cnt      = load_of(bus.freq_pattern_i[HEAD]);
            w_serial   = chan_vec(bus.sel_out_i, bus.output_pattern_i[HEAD]);
            w_bit_tick = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (w_cmd_stop) begin
          w_state  = S_DONE;
          w_serial = '0;
        end else begin
          // A start while running is refused; the active pattern keeps going untouched.
          w_err_tick = w_cmd_start;
          if (r_cnt != '0) begin
            w_cnt = r_cnt - 1'b1;
          end else if ((r_idx == IDX_LAST) && !r_mode) begin
            w_state  = S_DONE;
            w_serial = '0;
          end else begin
            w_idx      = (r_idx == IDX_LAST) ? IDX_FIRST : w_idx_adv;
            w_shift    = w_shift_rot;
            w_freq     = w_freq_rot;
            w_cnt      = load_of(w_freq_rot[HEAD]);
            w_serial   = chan_vec(r_ch, w_shift_rot[HEAD]);
            w_bit_tick = 1'b1;
          end
        end
      end

      default: begin
        w_state  = S_IDLE;
        w_serial = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_freq      <= '0;
      r_ch        <= '0;
      r_mode      <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_serial    <= '0;
      r_busy      <= 1'b0;
      r_bit_tick  <= 1'b0;
      r_done_tick <= 1'b0;
      r_err_tick  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_freq      <= w_freq;
      r_ch        <= w_ch;
      r_mode      <= w_mode;
      r_idx       <= w_idx;
      r_cnt       <= w_cnt;
      r_serial    <= w_serial;
      r_busy      <= (w_state == S_RUN);
      r_bit_tick  <= w_bit_tick;
      r_done_tick <= (w_state == S_DONE);
      r_err_tick  <= w_err_tick;
    end
  end

  assign bus.serial_o    = r_serial;
  assign bus.busy_o      = r_busy;
  assign bus.bit_tick_o  = r_bit_tick;
  assign bus.done_tick_o = r_done_tick;
  assign bus.err_tick_o  = r_err_tick;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: stimulus queues per-cycle expected outputs, a negedge monitor checks them.
module tb_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_sequencer_if #(.DATA_BIT(32), .CHANNEL_NUM(16)) bus0 ();
  pattern_sequencer_if #(.DATA_BIT(32), .CHANNEL_NUM(8))  bus1 ();

  pattern_sequencer #(.DATA_BIT(32), .CHANNEL_NUM(16), .DIV_BIT(8), .HIGH_DIV(10), .LOW_DIV(40))
    u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  pattern_sequencer #(.DATA_BIT(32), .CHANNEL_NUM(8), .DIV_BIT(8), .HIGH_DIV(10), .LOW_DIV(40))
    u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] serial;
    logic        busy;
    logic        tick;
    logic        done;
    logic        err;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [15:0] act_serial;
  logic [3:0]  act_flags;

  // Monitor: every expected entry due at or before this cycle is popped and compared.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.dut == 0) begin
        act_serial = bus0.serial_o;
        act_flags  = {bus0.busy_o, bus0.bit_tick_o, bus0.done_tick_o, bus0.err_tick_o};
      end else begin
        act_serial = {8'h00, bus1.serial_o};
        act_flags  = {bus1.busy_o, bus1.bit_tick_o, bus1.done_tick_o, bus1.err_tick_o};
      end
      n_vec++;
      if (mon_e.cyc != cyc || act_serial !== mon_e.serial ||
          act_flags !== {mon_e.busy, mon_e.tick, mon_e.done, mon_e.err}) begin
        n_miss++;
        $display("FAIL %s dut%0d cyc=%0d (due %0d): got serial=%h busy/tick/done/err=%b, required serial=%h busy/tick/done/err=%b",
                 mon_e.tag, mon_e.dut, cyc, mon_e.cyc, act_serial, act_flags,
                 mon_e.serial, {mon_e.busy, mon_e.tick, mon_e.done, mon_e.err});
      end
    end
  end

  task automatic push_one(input int dut, input int c, input logic [15:0] s,
                          input logic b, input logic t, input logic d, input string tag);
    exp_t e;
    e.cyc = c; e.dut = dut; e.serial = s; e.busy = b; e.tick = t; e.done = d; e.err = 1'b0; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_idle(input int dut, input int c, input int n, input string tag);
    for (int i = 0; i < n; i++) push_one(dut, c + i, 16'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic mark_err(input int dut, input int c);
    foreach (q[i]) if (q[i].dut == dut && q[i].cyc == c) q[i].err = 1'b1;
  endtask

  // Expands a command into its cycle-by-cycle output stream. t_cut (if >=0) ends the run
  // with a quiet cycle there: a DONE cycle for a stop, or an all-zero cycle for a reset.
  task automatic push_run(input int dut, input int t0, input logic [31:0] pat, input logic [31:0] freq,
                          input int ch, input bit mode, input int t_cut, input bit cut_done,
                          input string tag, output int t_end);
    int t, idx, per;
    bit cut, fin;
    t = t0; cut = 1'b0; fin = 1'b0;
    while (!fin) begin
      for (int k = 0; k < 32 && !cut; k++) begin
`ifdef SEQ_MSB_FIRST_EN
        idx = 31 - k;
`else
        idx = k;
`endif
        per = freq[idx] ? 10 : 40;
        for (int p = 0; p < per && !cut; p++) begin
          if (t == t_cut) begin
            cut = 1'b1;
          end else begin
            push_one(dut, t, pat[idx] ? (16'h1 << ch) : 16'h0, 1'b1, p == 0, 1'b0, tag);
            t++;
          end
        end
      end
      if (cut || !mode) fin = 1'b1;
    end
    if (cut) push_one(dut, t, 16'h0, 1'b0, 1'b0, cut_done, tag);
    else     push_one(dut, t, 16'h0, 1'b0, 1'b0, 1'b1, tag);
    t_end = t;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic drive(input int dut, input logic [31:0] pat, input logic [31:0] freq,
                       input logic [3:0] sel, input logic mode, input logic start, input logic stop);
    if (dut == 0) begin
      bus0.cmd_valid_i = 1'b1; bus0.output_pattern_i = pat; bus0.freq_pattern_i = freq;
      bus0.sel_out_i = sel; bus0.mode_i = mode; bus0.start_i = start; bus0.stop_i = stop;
    end else begin
      bus1.cmd_valid_i = 1'b1; bus1.output_pattern_i = pat; bus1.freq_pattern_i = freq;
      bus1.sel_out_i = sel; bus1.mode_i = mode; bus1.start_i = start; bus1.stop_i = stop;
    end
    step(1);
    bus0.cmd_valid_i = 1'b0; bus0.start_i = 1'b0; bus0.stop_i = 1'b0;
    bus0.output_pattern_i = '0; bus0.freq_pattern_i = '0; bus0.sel_out_i = '0; bus0.mode_i = 1'b0;
    bus1.cmd_valid_i = 1'b0; bus1.start_i = 1'b0; bus1.stop_i = 1'b0;
    bus1.output_pattern_i = '0; bus1.freq_pattern_i = '0; bus1.sel_out_i = '0; bus1.mode_i = 1'b0;
  endtask

  initial begin
    int c, te;
    bus0.cmd_valid_i = 1'b0; bus0.start_i = 1'b0; bus0.stop_i = 1'b0;
    bus0.output_pattern_i = '0; bus0.freq_pattern_i = '0; bus0.sel_out_i = '0; bus0.mode_i = 1'b0;
    bus1.cmd_valid_i = 1'b0; bus1.start_i = 1'b0; bus1.stop_i = 1'b0;
    bus1.output_pattern_i = '0; bus1.freq_pattern_i = '0; bus1.sel_out_i = '0; bus1.mode_i = 1'b0;

    // Reset state on both instances.
    step(1);
    for (int i = 2; i < 6; i++) begin
      push_one(0, i, 16'h0, 1'b0, 1'b0, 1'b0, "reset");
      push_one(1, i, 16'h0, 1'b0, 1'b0, 1'b0, "reset8");
    end
    step(1);
    rst = 1'b0;
    wait_to(6);

    // One-shot, all HIGH_DIV: 320 busy cycles then DONE.
    c = cyc;
    push_run(0, c + 1, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 3, 1'b0, -1, 1'b0, "oneshot", te);
    drive(0, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 4'd3, 1'b0, 1'b1, 1'b0);
    wait_to(te);

    // Mixed periods, started in the DONE cycle of the previous command.
    c = cyc;
    push_run(0, c + 1, 32'h0000_0003, 32'h0000_0001, 0, 1'b0, -1, 1'b0, "mixed_b2b", te);
    drive(0, 32'h0000_0003, 32'h0000_0001, 4'd0, 1'b0, 1'b1, 1'b0);
    wait_to(te);
    push_idle(0, te + 1, 3, "idle_after_mixed");
    wait_to(te + 3);

    // Repeat on channel 15: wraps at 320 with no gap, then stop.
    c = cyc;
    push_run(0, c + 1, 32'h0000_0001, 32'hFFFF_FFFF, 15, 1'b1, c + 351, 1'b1, "repeat_stop", te);
    drive(0, 32'h0000_0001, 32'hFFFF_FFFF, 4'd15, 1'b1, 1'b1, 1'b0);
    wait_to(c + 350);
    drive(0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    push_idle(0, te + 1, 3, "idle_after_stop");
    wait_to(te + 3);

    // Start during RUN is refused; start+stop together acts as a stop only.
    c = cyc;
    push_run(0, c + 1, 32'h0F0F_3C3C, 32'hAAAA_5555, 5, 1'b0, c + 121, 1'b1, "err_in_run", te);
    drive(0, 32'h0F0F_3C3C, 32'hAAAA_5555, 4'd5, 1'b0, 1'b1, 1'b0);
    wait_to(c + 20);
    mark_err(0, c + 21);
    drive(0, 32'hFFFF_FFFF, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0);
    wait_to(c + 120);
    drive(0, 32'hFFFF_FFFF, 32'h0, 4'd2, 1'b0, 1'b1, 1'b1);
    push_idle(0, te + 1, 3, "idle_after_startstop");
    wait_to(te + 3);

    // Reset during bit 5, then a fresh command.
    c = cyc;
    push_run(0, c + 1, 32'h0000_0021, 32'hFFFF_FFFF, 7, 1'b0, c + 54, 1'b0, "rst_mid_run", te);
    drive(0, 32'h0000_0021, 32'hFFFF_FFFF, 4'd7, 1'b0, 1'b1, 1'b0);
    wait_to(c + 53);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    c = cyc;
    push_run(0, c + 1, 32'hDEAD_BEEF, 32'h0000_FFFF, 9, 1'b0, -1, 1'b0, "after_rst", te);
    drive(0, 32'hDEAD_BEEF, 32'h0000_FFFF, 4'd9, 1'b0, 1'b1, 1'b0);
    wait_to(te);
    push_idle(0, te + 1, 3, "idle_after_rst_run");
    wait_to(te + 3);

    // 8-channel instance: sel 15 and sel 8 rejected while staying idle, sel 7 accepted.
    c = cyc;
    push_idle(1, c + 1, 4, "sel_range");
    mark_err(1, c + 1);
    mark_err(1, c + 3);
    drive(1, 32'h0000_0001, 32'h0000_0001, 4'd15, 1'b0, 1'b1, 1'b0);
    step(1);
    drive(1, 32'h0000_0001, 32'h0000_0001, 4'd8, 1'b0, 1'b1, 1'b0);
    step(1);
    push_run(1, c + 5, 32'h0000_0001, 32'h0000_0001, 7, 1'b0, c + 20, 1'b1, "ch7_ok", te);
    drive(1, 32'h0000_0001, 32'h0000_0001, 4'd7, 1'b0, 1'b1, 1'b0);
    wait_to(c + 19);
    drive(1, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    push_idle(1, te + 1, 3, "idle8");
    wait_to(te + 5);

    if (q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL leftover_expectations: got %0d unchecked entries, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    n_miss++;
    $display("FAIL watchdog: got cycle %0d without completion, required completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
